serial_to_parallel: RTL and testbench

- Deserializer that consumes the single-bit stream produced by the parallel-to-serial stage and reassembles it into DEPTH-bit words.
- Sits directly downstream of the serializer: the same SHIFT_EN strobe qualifies each incoming bit.
- Completed words are presented on a VALID/READY holding register with a sticky overflow flag for dropped words.
- Bit order matches the serializer: first bit received lands in DATA_OUT[0], i.e. LSB first.

---
 rtl/serial_to_parallel_pkg.sv | 23 ++
 rtl/serial_to_parallel.sv | 98 +++++++++
 tb/tb_serial_to_parallel.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_pkg.sv
// Shared serial-link definitions used by both the serializer and the
// deserializer so that both ends agree on bit order and counter sizing.
package serial_to_parallel_pkg;

   // Both link ends move the least significant bit first.
   localparam bit FIRST_BIT_IS_LSB = 1'b1;

   // States of the output holding register.
   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   // Width of a counter that indexes n bit positions.
   // Never less than one bit, so that a counter port always exists.
   function automatic int unsigned cnt_width(input int unsigned n);
      if (n < 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Deserializer: gathers SHIFT_EN-qualified serial bits (LSB first) into
// DEPTH-bit words and presents each completed word on a VALID/READY holding
// register. A word that completes while the holding register is still full
// and not being read is dropped, and the sticky OVERFLOW flag is set.
module serial_to_parallel
   import serial_to_parallel_pkg::*;
#(
   parameter int unsigned DEPTH = 3
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          DATA,
   input  logic                          SHIFT_EN,
   input  logic                          CLEAR,
   input  logic                          READY,
   output logic [DEPTH-1:0]              DATA_OUT,
   output logic                          VALID,
   output logic [cnt_width(DEPTH)-1:0]   BIT_COUNT,
   output logic                          OVERFLOW
);

   localparam int unsigned CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DEPTH - 1);

   // Only the upper DEPTH-1 bits of the shift register are ever read back
   // (the bottom bit falls off on every shift), so just those are stored.
   logic [DEPTH-2:0] sr;
   logic [CW-1:0]    bit_cnt;
   logic [DEPTH-1:0] word;
   logic             shift;
   logic             complete;
   hold_state_t      state;

   // Candidate word and frame-completion decode for this edge.
   always_comb begin
      word     = {DATA, sr};
      shift    = SHIFT_EN && !CLEAR;
      complete = shift && (bit_cnt == LAST_BIT);
   end

   // Shift register and bit counter; CLEAR discards the partial word.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (CLEAR) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else if (SHIFT_EN) begin
         if (complete) begin
            sr      <= '0;
            bit_cnt <= '0;
         end else begin
            sr      <= word[DEPTH-1:1];
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Holding-register FSM with registered DATA_OUT, VALID and OVERFLOW.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= HOLD_EMPTY;
         DATA_OUT <= '0;
         VALID    <= 1'b0;
         OVERFLOW <= 1'b0;
      end else begin
         case (state)
            HOLD_EMPTY: begin
               if (complete) begin
                  DATA_OUT <= word;
                  VALID    <= 1'b1;
                  state    <= HOLD_FULL;
               end
            end
            HOLD_FULL: begin
               if (complete) begin
                  if (READY) begin
                     DATA_OUT <= word;
                  end else begin
                     OVERFLOW <= 1'b1;
                  end
               end else if (READY) begin
                  VALID <= 1'b0;
                  state <= HOLD_EMPTY;
               end
            end
            default: begin
               VALID <= 1'b0;
               state <= HOLD_EMPTY;
            end
         endcase
      end
   end

   assign BIT_COUNT = bit_cnt;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel (DEPTH=3): a table of directed
// vectors with hand-derived expectations, then random stimulus compared
// against a queue-based reference model.
module tb_serial_to_parallel;

   localparam int unsigned DEPTH = 3;

   logic             CLK;
   logic             RST_N;
   logic             DATA;
   logic             SHIFT_EN;
   logic             CLEAR;
   logic             READY;
   logic [DEPTH-1:0] DATA_OUT;
   logic             VALID;
   logic [1:0]       BIT_COUNT;
   logic             OVERFLOW;

   int total;
   int bad;

   serial_to_parallel #(.DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .DATA     (DATA),
      .SHIFT_EN (SHIFT_EN),
      .CLEAR    (CLEAR),
      .READY    (READY),
      .DATA_OUT (DATA_OUT),
      .VALID    (VALID),
      .BIT_COUNT(BIT_COUNT),
      .OVERFLOW (OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: received bits of the partial word, holding register.
   bit               pq[$];
   logic [DEPTH-1:0] m_data;
   logic             m_valid;
   logic             m_ovf;

   task automatic model_update(input logic r, d, se, cl, rdy);
      logic [DEPTH-1:0] w;
      bit done;
      bit taken;
      if (!r) begin
         pq.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         return;
      end
      done = 1'b0;
      w    = '0;
      if (cl) begin
         pq.delete();
      end else if (se) begin
         pq.push_back(d);
         if (pq.size() == DEPTH) begin
            foreach (pq[i]) w[i] = pq[i];
            done = 1'b1;
            pq.delete();
         end
      end
      taken = m_valid && rdy;
      if (done) begin
         if (m_valid && !taken) m_ovf = 1'b1;
         else begin
            m_data  = w;
            m_valid = 1'b1;
         end
      end else if (taken) begin
         m_valid = 1'b0;
      end
   endtask

   // Drive one cycle's inputs, let one rising edge pass, sample 1 time unit later.
   task automatic apply(input logic r, d, se, cl, rdy);
      RST_N    = r;
      DATA     = d;
      SHIFT_EN = se;
      CLEAR    = cl;
      READY    = rdy;
      @(posedge CLK);
      #1;
      model_update(r, d, se, cl, rdy);
   endtask

   task automatic check(input string tag, input int idx, input logic [DEPTH-1:0] ed,
                        input logic ev, input logic [1:0] ec, input logic eo);
      total += 4;
      if (DATA_OUT !== ed) begin
         bad++;
         $display("FAIL %s[%0d] data_out got=%b exp=%b", tag, idx, DATA_OUT, ed);
      end
      if (VALID !== ev) begin
         bad++;
         $display("FAIL %s[%0d] valid got=%b exp=%b", tag, idx, VALID, ev);
      end
      if (BIT_COUNT !== ec) begin
         bad++;
         $display("FAIL %s[%0d] bit_count got=%0d exp=%0d", tag, idx, BIT_COUNT, ec);
      end
      if (OVERFLOW !== eo) begin
         bad++;
         $display("FAIL %s[%0d] overflow got=%b exp=%b", tag, idx, OVERFLOW, eo);
      end
   endtask

   typedef struct {
      logic       r, d, se, cl, rdy;
      logic [2:0] ed;
      logic       ev;
      logic [1:0] ec;
      logic       eo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, d, se, cl, rdy,
                              input logic [2:0] ed, input logic ev,
                              input logic [1:0] ec, input logic eo);
      vec_t x;
      x.r = r; x.d = d; x.se = se; x.cl = cl; x.rdy = rdy;
      x.ed = ed; x.ev = ev; x.ec = ec; x.eo = eo;
      return x;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      pq.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
      RST_N = 1'b0; DATA = 1'b0; SHIFT_EN = 1'b0; CLEAR = 1'b0; READY = 1'b0;

      //           r  d  se cl rdy  data    v  cnt ovf
      // reset state
      tbl.push_back(v(0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
      // basic frame 1,1,0 with READY high; VALID lasts one cycle
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b000, 0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b000, 0, 2, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 3'b011, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 3'b011, 0, 0, 0));
      // two bits, then five idle edges with DATA=1, then final bit
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b011, 0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 3'b011, 0, 2, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(1, 1, 0, 0, 1, 3'b011, 0, 2, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b101, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 1, 3'b101, 0, 0, 0));
      // backpressure: 1,0,1 then 1,1,1 dropped, then READY drains
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b101, 0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b101, 0, 2, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b101, 1, 0, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b101, 1, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b101, 1, 2, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b101, 1, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 1, 3'b101, 0, 0, 1));
      // reset clears sticky OVERFLOW
      tbl.push_back(v(0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
      // hold 001, then read and complete 0,1,1 on the same edge
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b000, 0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b000, 0, 2, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b001, 1, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b001, 1, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b001, 1, 2, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b110, 1, 0, 0));
      // CLEAR with SHIFT_EN on what would have been the final bit
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b110, 1, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 0, 3'b110, 1, 2, 0));
      tbl.push_back(v(1, 1, 1, 1, 0, 3'b110, 1, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 3'b110, 0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 1, 3'b110, 0, 2, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b100, 1, 0, 0));
      // reset mid-frame overrides a simultaneous shift
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b100, 0, 1, 0));
      tbl.push_back(v(1, 1, 1, 0, 1, 3'b100, 0, 2, 0));
      tbl.push_back(v(0, 1, 1, 0, 1, 3'b000, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b000, 0, 1, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b000, 0, 2, 0));
      tbl.push_back(v(1, 0, 1, 0, 0, 3'b000, 1, 0, 0));

      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].d, tbl[i].se, tbl[i].cl, tbl[i].rdy);
         check("vec", i, tbl[i].ed, tbl[i].ev, tbl[i].ec, tbl[i].eo);
      end

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         logic r, d, se, cl, rdy;
         r   = ($urandom_range(0, 99) != 0);
         d   = 1'($urandom_range(0, 1));
         se  = ($urandom_range(0, 9) < 7);
         cl  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 1) == 1);
         apply(r, d, se, cl, rdy);
         check("rnd", i, m_data, m_valid, 2'(pq.size()), m_ovf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
